wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DAT_WIDTH, default 64, SHALL set data bus width; sel width SHALL be DAT_WIDTH/8.
REQ-002 Parameter ADR_WIDTH, default 64, SHALL set address bus width.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the max cycles a strobed slave access may wait for ack/err (range 2..255).
REQ-004 clk_i  in  1  single clock; all state SHALL update on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 m{0,1}_cyc_i  in  1  master N bus cycle request.
REQ-007 m{0,1}_stb_i  in  1  master N strobe.
REQ-008 m{0,1}_we_i  in  1  master N write enable.
REQ-009 m{0,1}_sel_i  in  DAT_WIDTH/8  master N byte select.
REQ-010 m{0,1}_adr_i  in  ADR_WIDTH  master N address.
REQ-011 m{0,1}_dat_i  in  DAT_WIDTH  master N write data.
REQ-012 m{0,1}_dat_o  out  DAT_WIDTH  read data to master N.
REQ-013 m{0,1}_ack_o  out  1  ack to master N.
REQ-014 m{0,1}_err_o  out  1  error to master N (slave err or timeout).
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write enable.
REQ-016 s_sel_o  out  DAT_WIDTH/8;  s_adr_o  out  ADR_WIDTH;  s_dat_o  out  DAT_WIDTH  slave select/address/write data.
REQ-017 s_dat_i  in  DAT_WIDTH;  s_ack_i  in  1;  s_err_i  in  1  slave read data/ack/error.

Function
REQ-018 FSM SHALL have states IDLE and BUSY plus registered owner (0/1) and last_grant bit.
REQ-019 IDLE: if exactly one mN_cyc_i high, SHALL enter BUSY with owner=N next edge.
REQ-020 IDLE with both cyc high: SHALL grant master != last_grant (round-robin); last_grant SHALL update to new owner.
REQ-021 Grant latency: owner's signals SHALL reach slave port on the cycle after cyc is first sampled high.
REQ-022 BUSY: s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally mirror owner inputs; in IDLE all SHALL be 0.
REQ-023 BUSY: owner mN_dat_o/ack_o/err_o SHALL combinationally mirror s_dat_i/s_ack_i/s_err_i; non-owner outputs SHALL be 0.
REQ-024 Grant SHALL be held for the whole tenure (multiple strobes allowed); non-owner requests SHALL wait.
REQ-025 BUSY with owner cyc low at an edge: SHALL return to IDLE; at least one IDLE cycle between tenures.
REQ-026 Timeout counter SHALL increment each cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0, clear otherwise.
REQ-027 Counter at TIMEOUT-1 with no ack/err: owner err_o SHALL pulse 1 for the next cycle and counter SHALL clear; state stays BUSY.
REQ-028 s_ack_i and timeout in same cycle: ack SHALL win, no err pulse.
REQ-029 Slave ack/err while IDLE SHALL be ignored (no master output).

Reset
REQ-030 rst_i high at an edge SHALL force IDLE, owner=0, last_grant=1, counter=0, any pending timeout err cleared; all outputs 0 next cycle, including mid-tenure.
REQ-031 After reset release, first contested grant SHALL go to m0.

Verification
REQ-032 m0 only: cyc/stb=1, adr=0x8, slave acks after 2 cycles with dat 0xDEADBEEF00000001 -> s_adr_o=0x8 one cycle after request; m0_ack_o=1 with that data; m1 outputs 0.
REQ-033 Both cyc rise same cycle after reset -> m0 granted; after m0 drops cyc, one IDLE cycle, then m1 granted; next contest -> m0.
REQ-034 m1 owns, issues 3 strobes at adr 0x0/0x8/0x10 -> all three acked to m1, m0 (requesting) never reaches slave until m1 drops cyc.
REQ-035 TIMEOUT=4, slave never acks -> owner err_o=1 exactly one cycle, 4 cycles after s_stb_o rises; no ack_o.
REQ-036 s_ack_i at the cycle counter=TIMEOUT-1 -> ack_o=1, err_o stays 0.
REQ-037 rst_i pulsed mid-tenure -> next cycle s_cyc_o=0, all master outputs 0, state IDLE; contested request then grants m0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Wishbone classic bus bundle shared by both master ports and the slave port of wb_arbiter.
// The master modport drives the request side; the slave modport returns data/ack/err.
interface wb_arbiter_if #(
  parameter int unsigned DAT_WIDTH = 64,
  parameter int unsigned ADR_WIDTH = 64
);
  logic                   cyc;
  logic                   stb;
  logic                   we;
  logic [DAT_WIDTH/8-1:0] sel;
  logic [ADR_WIDTH-1:0]   adr;
  logic [DAT_WIDTH-1:0]   dat_w;
  logic [DAT_WIDTH-1:0]   dat_r;
  logic                   ack;
  logic                   err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with a per-strobe slave timeout.
// The owner holds the bus for its whole cyc tenure; a stalled strobe gets a one-cycle err pulse.
module wb_arbiter #(
  parameter int unsigned DAT_WIDTH = 64,
  parameter int unsigned ADR_WIDTH = 64,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_arbiter_if.slave   m0,
  wb_arbiter_if.slave   m1,
  wb_arbiter_if.master  s
);
  localparam int unsigned SelWidth = DAT_WIDTH / 8;
  localparam logic [7:0]  CntMax   = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     r_state;
  logic       r_owner;
  logic       r_last_grant;
  logic [7:0] r_cnt;
  logic       r_to_err;

  logic                 w_busy;
  logic                 w_cyc;
  logic                 w_stb;
  logic                 w_we;
  logic [SelWidth-1:0]  w_sel;
  logic [ADR_WIDTH-1:0] w_adr;
  logic [DAT_WIDTH-1:0] w_dat;
  logic                 w_stall;

  assign w_busy  = (r_state == StBusy);
  assign w_cyc   = r_owner ? m1.cyc   : m0.cyc;
  assign w_stb   = w_busy & (r_owner ? m1.stb : m0.stb);
  assign w_we    = r_owner ? m1.we    : m0.we;
  assign w_sel   = r_owner ? m1.sel   : m0.sel;
  assign w_adr   = r_owner ? m1.adr   : m0.adr;
  assign w_dat   = r_owner ? m1.dat_w : m0.dat_w;
  // Ack or err from the slave this cycle always beats the timeout.
  assign w_stall = w_stb & ~s.ack & ~s.err;

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.sel    = '0;
    s.adr    = '0;
    s.dat_w  = '0;
    m0.dat_r = '0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    if (w_busy) begin
      s.cyc   = w_cyc;
      s.stb   = w_stb;
      s.we    = w_we;
      s.sel   = w_sel;
      s.adr   = w_adr;
      s.dat_w = w_dat;
      if (r_owner) begin
        m1.dat_r = s.dat_r;
        m1.ack   = s.ack;
        m1.err   = s.err | r_to_err;
      end else begin
        m0.dat_r = s.dat_r;
        m0.ack   = s.ack;
        m0.err   = s.err | r_to_err;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_to_err     <= 1'b0;
    end else begin
      r_to_err <= 1'b0;
      if (w_stall) begin
        if (r_cnt == CntMax) begin
          r_cnt    <= '0;
          r_to_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= '0;
      end

      unique case (r_state)
        StIdle: begin
          if (m0.cyc && m1.cyc) begin
            r_owner      <= ~r_last_grant;
            r_last_grant <= ~r_last_grant;
            r_state      <= StBusy;
          end else if (m0.cyc) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= StBusy;
          end else if (m1.cyc) begin
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= StBusy;
          end
        end
        StBusy: begin
          if (!w_cyc) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: grant, round-robin, hold, timeout, reset.
module tb_wb_arbiter;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) m0_if ();
  wb_arbiter_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) m1_if ();
  wb_arbiter_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) s_if ();

  wb_arbiter #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.sel = '1;
    m0_if.adr = 64'h100; m0_if.dat_w = 64'h1111;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 1; m1_if.sel = '1;
    m1_if.adr = 64'h200; m1_if.dat_w = 64'h2222;
    s_if.ack = 0; s_if.err = 0; s_if.dat_r = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    do_reset();
    #1;
    check("reset_s_cyc", 64'(s_if.cyc), 0);
    check("reset_m0_ack", 64'(m0_if.ack), 0);

    // Single master read, slave acks two cycles after grant.
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 64'h8;
    #1;
    check("t1_not_yet_granted", 64'(s_if.cyc), 0);
    tick();
    #1;
    check("t1_s_adr", s_if.adr, 64'h8);
    check("t1_s_stb", 64'(s_if.stb), 1);
    tick();
    s_if.ack = 1; s_if.dat_r = 64'hDEADBEEF00000001;
    #1;
    check("t1_m0_ack", 64'(m0_if.ack), 1);
    check("t1_m0_dat", m0_if.dat_r, 64'hDEADBEEF00000001);
    check("t1_m1_ack", 64'(m1_if.ack), 0);
    check("t1_m1_dat", m1_if.dat_r, 0);
    tick();
    s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    tick();
    s_if.ack = 1;
    #1;
    check("idle_s_cyc", 64'(s_if.cyc), 0);
    check("idle_ack_ignored_m0", 64'(m0_if.ack), 0);
    check("idle_ack_ignored_m1", 64'(m1_if.ack), 0);
    s_if.ack = 0;

    // Round-robin contest.
    do_reset();
    m0_if.cyc = 1; m1_if.cyc = 1;
    tick();
    #1;
    check("t2_first_grant_m0", s_if.adr, 64'h100);
    tick();
    m0_if.cyc = 0;
    tick();
    #1;
    check("t2_idle_gap", 64'(s_if.cyc), 0);
    tick();
    #1;
    check("t2_m1_granted", s_if.adr, 64'h200);
    m0_if.cyc = 1;
    tick();
    #1;
    check("t2_m1_held", s_if.adr, 64'h200);
    m1_if.cyc = 0;
    tick();
    #1;
    check("t2_idle_gap2", 64'(s_if.cyc), 0);
    m1_if.cyc = 1;
    tick();
    #1;
    check("t2_next_contest_m0", s_if.adr, 64'h100);
    idle_all();
    tick();

    // m1 tenure with three strobes while m0 waits.
    do_reset();
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 64'h0;
    tick();
    m0_if.cyc = 1;
    for (int i = 0; i < 3; i++) begin
      m1_if.adr = 64'(i * 8);
      #1;
      check("t3_s_adr", s_if.adr, 64'(i * 8));
      s_if.ack = 1; s_if.dat_r = 64'(i + 'h55);
      #1;
      check("t3_m1_ack", 64'(m1_if.ack), 1);
      check("t3_m1_dat", m1_if.dat_r, 64'(i + 'h55));
      check("t3_m0_ack", 64'(m0_if.ack), 0);
      tick();
      s_if.ack = 0;
    end
    m1_if.cyc = 0; m1_if.stb = 0;
    tick();
    #1;
    check("t3_idle_gap", 64'(s_if.cyc), 0);
    tick();
    #1;
    check("t3_m0_granted", s_if.adr, 64'h100);
    idle_all();
    tick();

    // Timeout with no ack: err 4 cycles after stb rises, for one cycle.
    do_reset();
    m0_if.cyc = 1; m0_if.stb = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("t4_err_c%0d", k), 64'(m0_if.err), (k == 4) ? 64'd1 : 64'd0);
      check($sformatf("t4_ack_c%0d", k), 64'(m0_if.ack), 0);
      tick();
    end
    idle_all();
    tick();

    // Ack arriving on the timeout cycle wins.
    do_reset();
    m0_if.cyc = 1; m0_if.stb = 1;
    tick();
    tick();
    tick();
    tick();
    s_if.ack = 1;
    #1;
    check("t5_ack", 64'(m0_if.ack), 1);
    check("t5_err_same", 64'(m0_if.err), 0);
    tick();
    s_if.ack = 0;
    #1;
    check("t5_err_next", 64'(m0_if.err), 0);
    idle_all();
    tick();

    // Reset mid-tenure, then contested grant goes to m0.
    do_reset();
    m1_if.cyc = 1; m1_if.stb = 1;
    tick();
    #1;
    check("t6_m1_owns", s_if.adr, 64'h200);
    rst = 1; m0_if.cyc = 1; s_if.ack = 1;
    tick();
    rst = 0;
    #1;
    check("t6_s_cyc", 64'(s_if.cyc), 0);
    check("t6_m1_ack", 64'(m1_if.ack), 0);
    check("t6_m0_ack", 64'(m0_if.ack), 0);
    s_if.ack = 0;
    tick();
    #1;
    check("t6_contest_m0", s_if.adr, 64'h100);
    idle_all();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
